// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction path: command classes, RV32I opcodes,
// SECDED codeword layout and the encode helpers used by the loader.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_ITYPE  = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENC   = 2'd1,
        ST_WRITE = 2'd2
    } ldr_state_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int CW_W    = 32'sd39;
    localparam int NUM_CHK = 32'sd6;
    localparam logic [5:0] CHK_POS [NUM_CHK] = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};

    function automatic logic class_legal(input logic [2:0] cls);
        return (cls <= 3'd4);
    endfunction

    function automatic logic [31:0] encode_instr(
        input logic [2:0]  cls,
        input logic [2:0]  f3,
        input logic        f7b5,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [12:0] imm
    );
        logic [31:0] w;
        case (cls)
            CLS_LOAD:   w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
            CLS_ITYPE:  w = {imm[11:0], rs1, f3, rd, OPC_ITYPE};
            CLS_RTYPE:  w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OPC_RTYPE};
            CLS_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
            CLS_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
            default:    w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Data fills non-power-of-two positions; each check bit covers indices with its bit set.
    function automatic logic [CW_W-1:0] secded_encode(input logic [31:0] d);
        logic [CW_W-1:0] c;
        int unsigned     di;
        c  = '0;
        di = 32'd0;
        for (int pos = 32'sd1; pos < CW_W; pos++) begin
            if ((pos & (pos - 32'sd1)) != 32'sd0) begin
                c[pos] = d[di];
                di++;
            end
        end
        for (int k = 32'sd0; k < NUM_CHK; k++) begin
            for (int pos = 32'sd1; pos < CW_W; pos++) begin
                if (((pos & (32'sd1 << k)) != 32'sd0) && (pos != int'(CHK_POS[k]))) begin
                    c[CHK_POS[k]] = c[CHK_POS[k]] ^ c[pos];
                end
            end
        end
        c[0] = ^c[CW_W-1:1];
        return c;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_secded.sv
// Combinational Hamming(38,32) + overall-parity encoder, shared with the fetch-side checker.
module secded_enc_32
    import instr_enc_pkg::*;
(
    input  logic [31:0]     data_i,
    output logic [CW_W-1:0] code_o
);

    assign code_o = secded_encode(data_i);

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts decoded-field commands, encodes RV32I words, SECDED-protects them and
// writes them sequentially into instruction memory starting at BASE_ADDR.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 32'sd8,
    parameter int BASE_ADDR = 32'sd0
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CW_W-1:0]   mem_wdata,
    output logic [31:0]       instr_dbg,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    ldr_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              err_q;
    logic              illegal_q;
    logic              mem_we_q;
    logic [CW_W-1:0]   mem_wdata_q;
    logic [31:0]       instr_dbg_q;
    logic [31:0]       enc_word_s;
    logic              legal_s;
    logic [CW_W-1:0]   code_s;

    assign legal_s    = class_legal(in_class);
    assign enc_word_s = encode_instr(in_class, in_funct3, in_funct7b5, in_rd, in_rs1, in_rs2, in_imm);

    secded_enc_32 u_secded (
        .data_i (instr_dbg_q),
        .code_o (code_s)
    );

    // Loader FSM: encodes at acceptance so instr_dbg is visible one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= BASE_A;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            illegal_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            instr_dbg_q <= 32'h0000_0000;
        end else if (clear) begin
            state_q   <= ST_IDLE;
            addr_q    <= BASE_A;
            count_q   <= '0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !full_q) begin
                        illegal_q <= !legal_s;
                        err_q     <= !legal_s;
                        if (legal_s) begin
                            instr_dbg_q <= enc_word_s;
                        end
                        state_q <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    if (illegal_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= code_s;
                        state_q     <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The last address saturates instead of wrapping.
                    if (addr_q == ADDR_MAX) begin
                        full_q <= 1'b1;
                    end else begin
                        addr_q <= addr_q + ADDR_W'(1'b1);
                    end
                    count_q <= count_q + (ADDR_W + 1)'(1'b1);
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A clear landing in the write cycle must suppress that cycle's strobe.
    assign mem_we    = mem_we_q & ~clear;
    assign in_ready  = (state_q == ST_IDLE) & ~full_q & ~clear;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_wdata_q;
    assign instr_dbg = instr_dbg_q;
    assign full      = full_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule
